hex_display_ctrl: RTL and testbench
===================================

# hex_display_ctrl

Front-end controller for the board's seven-segment bank. It accepts a binary word over a valid/ready handshake and formats it as a hex or decimal digit string. Decimal values are converted with a sequential double-dabble. The block drives one 4-bit nibble plus one enable per digit, with leading-zero blanking. It sits directly upstream of the per-digit `Hex_to_7seg` instances: digit k feeds `i_data`, enable k feeds `i_en_hex`.

## Interface
Parameters:
- `SIZE_BIN`, 16: width of the input binary word.
- `NUM_DIGIT`, 5: number of display digits.
- `SIZE_DATA`, 4: nibble width per digit; fixed at 4.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  `i_data` / `i_mode_dec` are valid.
- `i_data`  in  SIZE_BIN  binary value to display.
- `i_mode_dec`  in  1  1 = decimal display, 0 = hex display; sampled only at accept.
- `o_ready`  out  1  block can accept a value.
- `o_digits`  out  NUM_DIGIT*SIZE_DATA  digit k on bits [4k+3:4k]; k=0 is the rightmost digit.
- `o_en_hex`  out  NUM_DIGIT  per-digit display enable.
- `o_ovf`  out  1  current value does not fit in NUM_DIGIT digits.
- `o_update`  out  1  one-cycle pulse; outputs refreshed this cycle.

## Operation
- States: IDLE, CONVERT, LOAD.
  - `o_ready` = (state == IDLE).
  - Accept occurs when `i_valid && o_ready` at a rising edge.
- **IDLE**
  - On accept, latch `i_data` into a shift register and latch the mode.
  - Hex mode goes to LOAD. Decimal mode clears the BCD scratch register, clears the iteration counter, and goes to CONVERT.
- **CONVERT** (decimal only)
  - Runs exactly SIZE_BIN iterations, one per cycle, MSB first.
  - Each iteration: every BCD digit ≥5 gets +3. The scratch register and the shift register then shift left together, with the binary MSB entering scratch bit 0.
  - A 1 shifted out of the scratch MSB sets an internal overflow flag.
  - After SIZE_BIN iterations (counter wraps from SIZE_BIN-1), go to LOAD.
- **Hex formatting:** digits are the low NUM_DIGIT*4 bits of the latched value, zero-extended if SIZE_BIN is smaller. Overflow = any latched bit at or above position NUM_DIGIT*4 is 1.
- **LOAD** (one cycle)
  - Register `o_digits`, `o_en_hex`, `o_ovf`; assert `o_update`; return to IDLE.
- **On overflow:** all digits = 4'hF, all enables = 1, `o_ovf` = 1.
- **Blanking (no overflow):** `o_en_hex[0]` = 1 always. `o_en_hex[k]`, k>0, = 1 iff any digit j ≥ k is nonzero. Zero therefore shows a single "0".
- Outputs hold between updates.
- `i_valid` while not ready is ignored; the upstream must hold its value.
- `i_data` and `i_mode_dec` changes after accept have no effect.

## Timing
- **Reset values** (asynchronous, immediate):
  - state IDLE, `o_ready` = 1
  - `o_digits` = 0, `o_en_hex` = 1 (digit 0 only), `o_ovf` = 0, `o_update` = 0
  - shift register, scratch register, and counter = 0
- **Hex latency:** accept at edge T; LOAD during cycle T+1, with new outputs and `o_update` = 1 in that cycle; IDLE from T+2.
- **Decimal latency:** accept at edge T; CONVERT cycles T+1..T+SIZE_BIN; LOAD/`o_update` at T+SIZE_BIN+1; IDLE from T+SIZE_BIN+2.
- **Throughput:** one value per 2 cycles in hex, one per SIZE_BIN+2 cycles in decimal.
- `o_ready` is low during LOAD. No same-cycle re-accept.
- **Reset mid-CONVERT or mid-LOAD:** conversion aborts, no `o_update`, all outputs take reset values.
- `o_update` is never high on two consecutive cycles.

## Structure
- **Shared package `display_pkg`:**
  - state enum {IDLE, CONVERT, LOAD}
  - constant DIGIT_W = 4
  - constant OVF_DIGIT = 4'hF
  - function `add3_if_ge5(logic [3:0])`
- **Sub-module `bin2bcd_step`:** combinational, one double-dabble iteration (per-digit add-3 then 1-bit shift in) over NUM_DIGIT digits. It outputs the next scratch value and the shifted-out bit. The controller FSM, counter, and output registers stay in `hex_display_ctrl`.
- Counter width = $clog2(SIZE_BIN+1).

## Test plan
- **Reset:** assert `i_rst` mid-operation; outputs go to `o_digits` = 0, `o_en_hex` = 5'b00001, `o_ready` = 1, `o_ovf` = 0, `o_update` = 0, with no clock edge needed.
- **Hex, defaults:** `i_data` = 16'h00A5, `i_mode_dec` = 0, accept at T. Required at T+1: `o_digits` = 20'h000A5, `o_en_hex` = 5'b00011, `o_update` pulse, `o_ovf` = 0.
- **Decimal, defaults:** `i_data` = 12345. Required at T+17: `o_digits` = 20'h12345, `o_en_hex` = 5'b11111. `o_ready` is low T+1..T+17; `i_valid` held high during CONVERT is not accepted.
- **Decimal zero:** `i_data` = 0 → `o_digits` = 0, `o_en_hex` = 5'b00001. Also `i_data` = 100 → `o_digits` = 20'h00100, `o_en_hex` = 5'b00111.
- **Overflow, NUM_DIGIT=4:**
  - Decimal 65535 → `o_ovf` = 1, `o_digits` = 16'hFFFF, `o_en_hex` = 4'b1111.
  - Decimal 9999 → `o_ovf` = 0, `o_digits` = 16'h9999.
  - Hex 16'hFFFF → no overflow.
- **Reset mid-CONVERT:** reset at T+8 of a decimal conversion → no `o_update`, reset values. The next accept converts correctly.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment front end.
// State encoding, digit constants and the BCD adjust step.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] OVF_DIGIT = 4'hF;

  // Double-dabble correction for one BCD digit.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Value handshake and display bus of the display controller.
// master = upstream producer, slave = hex_display_ctrl.
interface hex_display_ctrl_if #(
  parameter int SIZE_BIN  = 16,
  parameter int NUM_DIGIT = 5,
  parameter int SIZE_DATA = 4
);

  logic                           i_valid;
  logic [SIZE_BIN-1:0]            i_data;
  logic                           i_mode_dec;
  logic                           o_ready;
  logic [NUM_DIGIT*SIZE_DATA-1:0] o_digits;
  logic [NUM_DIGIT-1:0]           o_en_hex;
  logic                           o_ovf;
  logic                           o_update;

  modport master (
    output i_valid,
    output i_data,
    output i_mode_dec,
    input  o_ready,
    input  o_digits,
    input  o_en_hex,
    input  o_ovf,
    input  o_update
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_mode_dec,
    output o_ready,
    output o_digits,
    output o_en_hex,
    output o_ovf,
    output o_update
  );

endinterface

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration over NUM_DIGIT BCD digits:
// add-3 correction per digit, then shift one binary bit in.
module bin2bcd_step
  import display_pkg::*;
#(
  parameter int NUM_DIGIT = 5
) (
  input  logic [NUM_DIGIT*DIGIT_W-1:0] bcd_in,
  input  logic                         bit_in,
  output logic [NUM_DIGIT*DIGIT_W-1:0] bcd_out,
  output logic                         carry_out
);

  logic [NUM_DIGIT*DIGIT_W-1:0] adj;

  // Correct every digit before the shift.
  always_comb begin
    adj = '0;
    for (int k = 0; k < NUM_DIGIT; k++) begin
      adj[k*DIGIT_W +: DIGIT_W] =
        add3_if_ge5(bcd_in[k*DIGIT_W +: DIGIT_W]);
    end
  end

  assign {carry_out, bcd_out} = {adj, bit_in};

endmodule

// File: rtl/hex_display_ctrl.sv
// Formats a binary word as hex or decimal digits with
// leading-zero blanking for the seven-segment bank.
module hex_display_ctrl
  import display_pkg::*;
#(
  parameter int SIZE_BIN  = 16,
  parameter int NUM_DIGIT = 5,
  parameter int SIZE_DATA = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  hex_display_ctrl_if.slave bus
);

  localparam int NW   = NUM_DIGIT * SIZE_DATA;
  localparam int CW   = $clog2(SIZE_BIN + 1);
  localparam int MAXW = (SIZE_BIN > NW) ? SIZE_BIN : NW;

  state_t              state_q;
  state_t              state_d;
  logic [SIZE_BIN-1:0] shift_q;
  logic [NW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;

  logic                accept;
  logic                last_iter;
  logic                load_en;
  logic [NW-1:0]       bcd_nxt;
  logic                bcd_carry;
  logic [MAXW-1:0]     hex_ext;
  logic [NW-1:0]       fmt_val;
  logic                fmt_ovf;
  logic [NW-1:0]       fmt_digits;
  logic [NUM_DIGIT-1:0] fmt_en;

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_update = (state_q == LOAD);
  assign accept       = bus.i_valid && bus.o_ready;
  assign last_iter    = (cnt_q == CW'(SIZE_BIN - 1));
  assign hex_ext      = MAXW'(bus.i_data);

  bin2bcd_step #(
    .NUM_DIGIT (NUM_DIGIT)
  ) u_step (
    .bcd_in    (bcd_q),
    .bit_in    (shift_q[SIZE_BIN-1]),
    .bcd_out   (bcd_nxt),
    .carry_out (bcd_carry)
  );

  // Next state; load_en marks the edge entering LOAD.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = bus.i_mode_dec ? CONVERT : LOAD;
          load_en = !bus.i_mode_dec;
        end
      end
      CONVERT: begin
        if (last_iter) begin
          state_d = LOAD;
          load_en = 1'b1;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pick the value being loaded and format it with blanking.
  always_comb begin
    fmt_val    = hex_ext[NW-1:0];
    fmt_ovf    = |(hex_ext >> NW);
    fmt_digits = '0;
    fmt_en     = '0;
    if (state_q == CONVERT) begin
      fmt_val = bcd_nxt;
      fmt_ovf = ovf_q | bcd_carry;
    end
    if (fmt_ovf) begin
      fmt_digits = {NUM_DIGIT{OVF_DIGIT}};
      fmt_en     = '1;
    end else begin
      fmt_digits = fmt_val;
      for (int k = NUM_DIGIT - 1; k >= 0; k--) begin
        if (k == NUM_DIGIT - 1)
          fmt_en[k] = |fmt_val[k*SIZE_DATA +: SIZE_DATA];
        else
          fmt_en[k] = fmt_en[k+1] |
                      (|fmt_val[k*SIZE_DATA +: SIZE_DATA]);
      end
      fmt_en[0] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Conversion datapath: latch on accept, shift while converting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      shift_q <= bus.i_data;
      if (bus.i_mode_dec) begin
        bcd_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end else if (state_q == CONVERT) begin
      bcd_q   <= bcd_nxt;
      shift_q <= shift_q << 1;
      ovf_q   <= ovf_q | bcd_carry;
      cnt_q   <= last_iter ? '0 : cnt_q + 1'b1;
    end
  end

  // Display registers, refreshed on entry to LOAD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_digits <= '0;
      bus.o_en_hex <= NUM_DIGIT'(1);
      bus.o_ovf    <= 1'b0;
    end else if (load_en) begin
      bus.o_digits <= fmt_digits;
      bus.o_en_hex <= fmt_en;
      bus.o_ovf    <= fmt_ovf;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: 5-digit and 4-digit instances
// driven in lockstep and compared against a digit-string model.
module tb_hex_display_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hex_display_ctrl_if #(.SIZE_BIN(16), .NUM_DIGIT(5)) ifc5 ();
  hex_display_ctrl_if #(.SIZE_BIN(16), .NUM_DIGIT(4)) ifc4 ();

  hex_display_ctrl #(
    .SIZE_BIN (16),
    .NUM_DIGIT(5),
    .SIZE_DATA(4)
  ) u_dut5 (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (ifc5.slave)
  );

  hex_display_ctrl #(
    .SIZE_BIN (16),
    .NUM_DIGIT(4),
    .SIZE_DATA(4)
  ) u_dut4 (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (ifc4.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Display digits written out as a numeral in base 10 or 16.
  task automatic model(input int v, input bit dec, input int nd,
                       output logic [19:0] dig,
                       output logic [4:0] en, output logic ovf);
    int base;
    int lim;
    int p;
    int top;
    base = dec ? 10 : 16;
    lim  = 1;
    for (int i = 0; i < nd; i++) lim = lim * base;
    dig = '0;
    en  = '0;
    ovf = (v >= lim);
    if (ovf) begin
      for (int k = 0; k < nd; k++) begin
        dig[4*k +: 4] = 4'hF;
        en[k] = 1'b1;
      end
    end else begin
      p   = 1;
      top = 0;
      for (int k = 0; k < nd; k++) begin
        dig[4*k +: 4] = 4'((v / p) % base);
        if ((v / p) % base != 0) top = k;
        p = p * base;
      end
      for (int k = 0; k <= top; k++) en[k] = 1'b1;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic m);
    ifc5.i_valid    = v;
    ifc5.i_data     = d;
    ifc5.i_mode_dec = m;
    ifc4.i_valid    = v;
    ifc4.i_data     = d;
    ifc4.i_mode_dec = m;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dig5"}, 32'(ifc5.o_digits), 0);
    chk({tag, "_en5"}, 32'(ifc5.o_en_hex), 1);
    chk({tag, "_rdy5"}, 32'(ifc5.o_ready), 1);
    chk({tag, "_ovf5"}, 32'(ifc5.o_ovf), 0);
    chk({tag, "_upd5"}, 32'(ifc5.o_update), 0);
    chk({tag, "_dig4"}, 32'(ifc4.o_digits), 0);
    chk({tag, "_en4"}, 32'(ifc4.o_en_hex), 1);
    chk({tag, "_upd4"}, 32'(ifc4.o_update), 0);
  endtask

  // One accept, wait for the update pulse, compare both instances.
  task automatic do_txn(input logic [15:0] d, input logic m,
                        input bit hold_valid);
    logic [19:0] dig;
    logic [4:0]  en;
    logic        ovf;
    int          lat;
    bit          busy_rdy;
    @(negedge clk);
    drive(1'b1, d, m);
    @(posedge clk);
    #1;
    drive(hold_valid, 16'($urandom), 1'($urandom));
    lat      = 1;
    busy_rdy = 1'b0;
    while (!ifc5.o_update && lat < 40) begin
      if (ifc5.o_ready) busy_rdy = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    drive(1'b0, 16'($urandom), 1'b0);
    chk($sformatf("lat_%h_%0d", d, m), lat, m ? 17 : 1);
    chk("busy_ready", 32'(busy_rdy), 0);
    chk("load_ready", 32'(ifc5.o_ready), 0);
    chk("upd4", 32'(ifc4.o_update), 1);
    model(int'(d), m, 5, dig, en, ovf);
    chk($sformatf("dig5_%h_%0d", d, m), 32'(ifc5.o_digits), 32'(dig));
    chk($sformatf("en5_%h_%0d", d, m), 32'(ifc5.o_en_hex), 32'(en));
    chk($sformatf("ovf5_%h_%0d", d, m), 32'(ifc5.o_ovf), 32'(ovf));
    model(int'(d), m, 4, dig, en, ovf);
    chk($sformatf("dig4_%h_%0d", d, m), 32'(ifc4.o_digits), 32'(dig));
    chk($sformatf("en4_%h_%0d", d, m), 32'(ifc4.o_en_hex), 32'(en));
    chk($sformatf("ovf4_%h_%0d", d, m), 32'(ifc4.o_ovf), 32'(ovf));
    @(posedge clk);
    #1;
    chk("upd_once", 32'(ifc5.o_update), 0);
    chk("idle_ready", 32'(ifc5.o_ready), 1);
    model(int'(d), m, 5, dig, en, ovf);
    chk("hold_dig5", 32'(ifc5.o_digits), 32'(dig));
  endtask

  initial begin
    logic [15:0] edges [5];
    bit          upd_seen;
    logic [15:0] d;
    edges[0] = 16'd0;
    edges[1] = 16'd9999;
    edges[2] = 16'd10000;
    edges[3] = 16'd65535;
    edges[4] = 16'h1000;

    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0);
    #2;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    do_txn(16'h00A5, 1'b0, 1'b0);
    do_txn(16'd12345, 1'b1, 1'b1);
    do_txn(16'd0, 1'b1, 1'b0);
    do_txn(16'd100, 1'b1, 1'b0);
    do_txn(16'd65535, 1'b1, 1'b0);
    do_txn(16'd9999, 1'b1, 1'b0);
    do_txn(16'hFFFF, 1'b0, 1'b0);
    do_txn(16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a decimal conversion.
    @(negedge clk);
    drive(1'b1, 16'd4321, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("rst_conv");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    upd_seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ifc5.o_update || ifc4.o_update) upd_seen = 1'b1;
    end
    chk("no_upd_after_rst", 32'(upd_seen), 0);
    do_txn(16'd4321, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d = (i % 5 == 0) ? edges[i/5 % 5] : 16'($urandom);
      do_txn(d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
